// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives a synchronous instruction memory and tracks the
// instruction in EX through run/stall/redirect/halt control, with cycle and
// retired-instruction counters.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   run               level, execution permitted
//   stall             EX instruction cannot complete this cycle
//   redirect_valid    EX instruction is a taken branch/jump
//   redirect_target   word address of the branch/jump target
//   halt_req          EX instruction requests halt
//   pc_fetch          address presented to instruction memory (registered)
//   imem_en           instruction memory output-register enable (combinational)
//   pc_ex, valid_ex   address and validity of the instruction in EX
//   state_o           00 IDLE, 01 RUN, 10 HALT
//   cycle_count       cycles spent in RUN
//   instret           retired instructions
module fetch_sequencer #(
    parameter int unsigned AW       = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_target,
    input  logic          halt_req,
    output logic [AW-1:0] pc_fetch,
    output logic          imem_en,
    output logic [AW-1:0] pc_ex,
    output logic          valid_ex,
    output logic [1:0]    state_o,
    output logic [31:0]   cycle_count,
    output logic [31:0]   instret
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [AW-1:0] RESET_ADDR = AW'(RESET_PC);

    state_t        state_q,    state_d;
    logic [AW-1:0] pc_fetch_q, pc_fetch_d;
    logic [AW-1:0] pc_ex_q,    pc_ex_d;
    logic          valid_q,    valid_d;
    logic [31:0]   cycle_q,    cycle_d;
    logic [31:0]   instret_q,  instret_d;

    logic          adv;
    logic [AW-1:0] pc_inc;

    // EX instruction retires on this edge
    assign adv    = (state_q == ST_RUN) & valid_q & ~stall;
    // Increment wraps naturally at AW bits
    assign pc_inc = pc_fetch_q + AW'(1);

    // Next-state and datapath selection
    always_comb begin
        state_d    = state_q;
        pc_fetch_d = pc_fetch_q;
        pc_ex_d    = pc_ex_q;
        valid_d    = valid_q;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (run) begin
                    state_d    = ST_RUN;
                    pc_ex_d    = pc_fetch_q;
                    pc_fetch_d = pc_inc;
                    valid_d    = 1'b1;
                end
            end
            ST_RUN: begin
                if (valid_q && stall) begin
                    // Stalled instruction holds everything, including against
                    // run=0, so it is not lost before it completes.
                    state_d = ST_RUN;
                end else if (adv && halt_req) begin
                    state_d = ST_HALT;
                    valid_d = 1'b0;
                    if (redirect_valid) pc_fetch_d = redirect_target;
                end else if (!run) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    if (adv && redirect_valid) pc_fetch_d = redirect_target;
                end else if (adv && redirect_valid) begin
                    // One squashed bubble while memory fetches the target
                    pc_fetch_d = redirect_target;
                    valid_d    = 1'b0;
                end else begin
                    pc_ex_d    = pc_fetch_q;
                    pc_fetch_d = pc_inc;
                    valid_d    = 1'b1;
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
                if (!run) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // cycle_count reflects the number of cycles whose state is RUN,
        // including the cycle just entered.
        cycle_d   = (state_d == ST_RUN) ? cycle_q + 32'd1 : cycle_q;
        instret_d = adv ? instret_q + 32'd1 : instret_q;
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_fetch_q <= RESET_ADDR;
            pc_ex_q    <= RESET_ADDR;
            valid_q    <= 1'b0;
            cycle_q    <= 32'd0;
            instret_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_fetch_q <= pc_fetch_d;
            pc_ex_q    <= pc_ex_d;
            valid_q    <= valid_d;
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
        end
    end

    // Holding the memory output register keeps a stalled instruction stable
    assign imem_en     = ~((state_q == ST_RUN) & valid_q & stall);
    assign pc_fetch    = pc_fetch_q;
    assign pc_ex       = pc_ex_q;
    assign valid_ex    = valid_q;
    assign state_o     = state_q;
    assign cycle_count = cycle_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer (AW=12, RESET_PC=0).
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        stall;
    logic        redirect_valid;
    logic [11:0] redirect_target;
    logic        halt_req;
    logic [11:0] pc_fetch;
    logic        imem_en;
    logic [11:0] pc_ex;
    logic        valid_ex;
    logic [1:0]  state_o;
    logic [31:0] cycle_count;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.AW(12), .RESET_PC(0)) dut (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .pc_fetch        (pc_fetch),
        .imem_en         (imem_en),
        .pc_ex           (pc_ex),
        .valid_ex        (valid_ex),
        .state_o         (state_o),
        .cycle_count     (cycle_count),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; run = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0; halt_req = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        #1;
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL rst_state: got %b exp %b", state_o, 2'b00); end
        checks++; if (pc_fetch !== 12'h000) begin errors++; $display("FAIL rst_pc_fetch: got %h exp %h", pc_fetch, 12'h000); end
        checks++; if (pc_ex !== 12'h000) begin errors++; $display("FAIL rst_pc_ex: got %h exp %h", pc_ex, 12'h000); end
        checks++; if (valid_ex !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", valid_ex); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_cycle: got %0d exp 0", cycle_count); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL rst_instret: got %0d exp 0", instret); end
        checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL rst_imem_en: got %b exp 1", imem_en); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        apply_reset();
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (pc_ex !== 12'(i)) begin errors++; $display("FAIL seq_pc_ex[%0d]: got %h exp %h", i, pc_ex, 12'(i)); end
            checks++; if (valid_ex !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b exp 1", i, valid_ex); end
        end
        checks++; if (instret !== 32'd4) begin errors++; $display("FAIL seq_instret: got %0d exp 4", instret); end
        checks++; if (cycle_count !== 32'd5) begin errors++; $display("FAIL seq_cycle: got %0d exp 5", cycle_count); end
        checks++; if (pc_fetch !== 12'h005) begin errors++; $display("FAIL seq_pc_fetch: got %h exp %h", pc_fetch, 12'h005); end
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL seq_state: got %b exp 01", state_o); end
    endtask

    task automatic test_stall();
        apply_reset();
        run = 1'b1;
        step(); step(); step();   // pc_ex=2, pc_fetch=3, instret=2, cycle=3
        stall = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL stall_imem_en_comb: got %b exp 0", imem_en); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc_ex !== 12'h002 || pc_fetch !== 12'h003 || valid_ex !== 1'b1)
                begin errors++; $display("FAIL stall_hold[%0d]: got pc_ex=%h pc_fetch=%h valid=%b exp 002 003 1", i, pc_ex, pc_fetch, valid_ex); end
            checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL stall_imem_en[%0d]: got %b exp 0", i, imem_en); end
        end
        checks++; if (instret !== 32'd2) begin errors++; $display("FAIL stall_instret: got %0d exp 2", instret); end
        checks++; if (cycle_count !== 32'd6) begin errors++; $display("FAIL stall_cycle: got %0d exp 6", cycle_count); end
        stall = 1'b0;
        step();
        checks++; if (pc_ex !== 12'h003 || instret !== 32'd3) begin errors++; $display("FAIL stall_release: got pc_ex=%h instret=%0d exp 003 3", pc_ex, instret); end
    endtask

    task automatic test_redirect();
        step(); step();           // pc_ex=5, instret=5
        redirect_valid = 1'b1; redirect_target = 12'h100;
        step();
        checks++; if (valid_ex !== 1'b0) begin errors++; $display("FAIL redir_bubble: got %b exp 0", valid_ex); end
        checks++; if (pc_fetch !== 12'h100) begin errors++; $display("FAIL redir_pc_fetch: got %h exp 100", pc_fetch); end
        checks++; if (instret !== 32'd6) begin errors++; $display("FAIL redir_instret: got %0d exp 6", instret); end
        redirect_valid = 1'b0;
        step();
        checks++; if (pc_ex !== 12'h100 || valid_ex !== 1'b1) begin errors++; $display("FAIL redir_target_ex: got pc_ex=%h valid=%b exp 100 1", pc_ex, valid_ex); end
        checks++; if (pc_fetch !== 12'h101 || instret !== 32'd6) begin errors++; $display("FAIL redir_after: got pc_fetch=%h instret=%0d exp 101 6", pc_fetch, instret); end
        // Redirect and halt are ignored while stalled
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 12'h200; halt_req = 1'b1;
        step();
        checks++; if (pc_ex !== 12'h100 || pc_fetch !== 12'h101 || state_o !== 2'b01)
            begin errors++; $display("FAIL redir_stalled: got pc_ex=%h pc_fetch=%h state=%b exp 100 101 01", pc_ex, pc_fetch, state_o); end
        stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
    endtask

    task automatic test_halt();
        apply_reset();
        run = 1'b1;
        for (int i = 0; i < 8; i++) step();   // pc_ex=7, pc_fetch=8, instret=7
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++; if (state_o !== 2'b10 || valid_ex !== 1'b0) begin errors++; $display("FAIL halt_state: got state=%b valid=%b exp 10 0", state_o, valid_ex); end
        checks++; if (pc_fetch !== 12'h008) begin errors++; $display("FAIL halt_pc_fetch: got %h exp 008", pc_fetch); end
        checks++; if (instret !== 32'd8) begin errors++; $display("FAIL halt_instret: got %0d exp 8", instret); end
        step();
        checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL halt_hold: got %b exp 10", state_o); end
        run = 1'b0;
        step();
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL halt_to_idle: got %b exp 00", state_o); end
        run = 1'b1;
        step();
        checks++; if (pc_ex !== 12'h008 || valid_ex !== 1'b1 || pc_fetch !== 12'h009)
            begin errors++; $display("FAIL halt_resume: got pc_ex=%h valid=%b pc_fetch=%h exp 008 1 009", pc_ex, valid_ex, pc_fetch); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 12'hFFF;
        step();                   // retires 8 -> instret=9
        redirect_valid = 1'b0;
        checks++; if (pc_fetch !== 12'hFFF || valid_ex !== 1'b0) begin errors++; $display("FAIL wrap_redir: got pc_fetch=%h valid=%b exp FFF 0", pc_fetch, valid_ex); end
        step();
        checks++; if (pc_ex !== 12'hFFF || pc_fetch !== 12'h000) begin errors++; $display("FAIL wrap_edge: got pc_ex=%h pc_fetch=%h exp FFF 000", pc_ex, pc_fetch); end
        step();                   // retires FFF -> instret=10
        checks++; if (pc_ex !== 12'h000 || pc_fetch !== 12'h001 || valid_ex !== 1'b1)
            begin errors++; $display("FAIL wrap_after: got pc_ex=%h pc_fetch=%h valid=%b exp 000 001 1", pc_ex, pc_fetch, valid_ex); end
    endtask

    task automatic test_run_drop();
        run = 1'b0;
        step();                   // retires 0 -> instret=11, IDLE
        checks++; if (state_o !== 2'b00 || valid_ex !== 1'b0) begin errors++; $display("FAIL drop_state: got state=%b valid=%b exp 00 0", state_o, valid_ex); end
        checks++; if (pc_fetch !== 12'h001) begin errors++; $display("FAIL drop_pc_fetch: got %h exp 001", pc_fetch); end
        checks++; if (instret !== 32'd11) begin errors++; $display("FAIL drop_instret: got %0d exp 11", instret); end
        step();
        checks++; if (pc_fetch !== 12'h001 || valid_ex !== 1'b0) begin errors++; $display("FAIL idle_hold: got pc_fetch=%h valid=%b exp 001 0", pc_fetch, valid_ex); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        run = 1'b1;
        for (int i = 0; i < 10; i++) step();  // pc_ex=9, instret=9
        stall = 1'b1;
        step();
        checks++; if (instret !== 32'd9 || pc_ex !== 12'h009) begin errors++; $display("FAIL pre_reset: got instret=%0d pc_ex=%h exp 9 009", instret, pc_ex); end
        #2 reset = 1'b1;
        #1;
        checks++; if (state_o !== 2'b00 || pc_fetch !== 12'h000 || pc_ex !== 12'h000 || valid_ex !== 1'b0)
            begin errors++; $display("FAIL async_rst_pc: got state=%b pc_fetch=%h pc_ex=%h valid=%b exp 00 000 000 0", state_o, pc_fetch, pc_ex, valid_ex); end
        checks++; if (instret !== 32'd0 || cycle_count !== 32'd0) begin errors++; $display("FAIL async_rst_cnt: got instret=%0d cycle=%0d exp 0 0", instret, cycle_count); end
        checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL async_rst_imem_en: got %b exp 1", imem_en); end
        step();
        stall = 1'b0;
        reset = 1'b0;
        step();
        checks++; if (state_o !== 2'b01 || pc_ex !== 12'h000 || valid_ex !== 1'b1 || pc_fetch !== 12'h001)
            begin errors++; $display("FAIL first_edge: got state=%b pc_ex=%h valid=%b pc_fetch=%h exp 01 000 1 001", state_o, pc_ex, valid_ex, pc_fetch); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL first_edge_instret: got %0d exp 0", instret); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_run_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
